// File: rtl/timer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_seq_pkg
// Description : Shared definitions for the timer_seq block: default counter and
//               repeat-count widths, and the FSM state type with its encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_seq_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_REP_W = 4;

   // FSM state type; encodings kept as plain constants so legacy code that
   // compares raw state bits keeps working.
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_PAUSE = 2'd2;

endpackage : timer_seq_pkg
`default_nettype wire

// File: rtl/timer_seq_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_counter
// Description : Interval counter for timer_seq. Clears on clr, advances by one
//               on inc (clr has priority), otherwise holds. eq flags that the
//               count has reached the latched period.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               clr    - synchronous clear request
//               inc    - synchronous increment request
//               limit  - latched period to compare against
//               cnt    - current count
//               eq     - cnt == limit (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module tick_counter
   import timer_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] cnt,
   output logic             eq
);

   localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         // The controller only increments while cnt_q != limit, so this
         // never wraps.
         cnt_d = cnt_q + C_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign eq  = (cnt_q == limit);

endmodule : tick_counter
`default_nettype wire

// File: rtl/timer_seq.sv
`default_nettype none
// ============================================================================
// Module      : timer_seq
// Description : Repeating interval timer. On an accepted start it latches the
//               period and repeat count, then counts tick_en strobes; every
//               period+1 strobes it pulses tick, and after repeat+1 intervals
//               it also pulses done and returns to idle. stop aborts at any time.
//               Optional build macro TIMER_SEQ_PAUSE_EN adds a pause input and
//               a PAUSE state that freezes the sequence.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               start      - begin a sequence (accepted only when ready)
//               stop       - abort the current sequence
//               pause      - freeze the sequence (TIMER_SEQ_PAUSE_EN only)
//               tick_en    - prescaler strobe
//               period     - interval length minus one, in strobes
//               repeat_cnt - number of intervals minus one ("repeat" itself
//                            is a reserved word)
//               ready      - idle, start will be accepted
//               busy       - sequence in progress
//               tick       - registered pulse at each interval end
//               done       - registered pulse at the final interval end
//               cnt        - current counter value
//               rep_left   - intervals remaining after the current one
// Revision    : 1.0 - initial release
// ============================================================================
module timer_seq
   import timer_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REP_W = DEF_REP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
`ifdef TIMER_SEQ_PAUSE_EN
   input  logic             pause,
`endif
   input  logic             tick_en,
   input  logic [WIDTH-1:0] period,
   input  logic [REP_W-1:0] repeat_cnt,
   output logic             ready,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic [WIDTH-1:0] cnt,
   output logic [REP_W-1:0] rep_left
);

   localparam logic [REP_W-1:0] C_REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

   state_t           state_q,    state_d;
   logic [WIDTH-1:0] period_q,   period_d;
   logic [REP_W-1:0] rep_left_q, rep_left_d;
   logic             tick_q,     tick_d;
   logic             done_q,     done_d;

   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_eq;
   logic [WIDTH-1:0] cnt_val;

   logic             pause_req;

`ifdef TIMER_SEQ_PAUSE_EN
   assign pause_req = pause;
`else
   assign pause_req = 1'b0;
`endif

   tick_counter #(
      .WIDTH (WIDTH)
   ) u_tick_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .limit (period_q),
      .cnt   (cnt_val),
      .eq    (cnt_eq)
   );

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      rep_left_d = rep_left_q;
      tick_d     = 1'b0;
      done_d     = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // stop beats a coincident start.
            if (start && !stop) begin
               period_d   = period;
               rep_left_d = repeat_cnt;
               cnt_clr    = 1'b1;
               state_d    = ST_RUN;
            end
         end

         ST_RUN: begin
            // Priority: stop, then pause, then counting.
            if (stop) begin
               state_d    = ST_IDLE;
               rep_left_d = '0;
               cnt_clr    = 1'b1;
            end else if (pause_req) begin
               state_d = ST_PAUSE;
            end else if (tick_en) begin
               if (cnt_eq) begin
                  cnt_clr = 1'b1;
                  tick_d  = 1'b1;
                  if (rep_left_q != '0) begin
                     rep_left_d = rep_left_q - C_REP_ONE;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end

         ST_PAUSE: begin
            // Counter and rep_left hold; tick_en is ignored here.
            if (stop) begin
               state_d    = ST_IDLE;
               rep_left_d = '0;
               cnt_clr    = 1'b1;
            end else if (!pause_req) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            rep_left_d = '0;
            cnt_clr    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         period_q   <= '0;
         rep_left_q <= '0;
         tick_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         rep_left_q <= rep_left_d;
         tick_q     <= tick_d;
         done_q     <= done_d;
      end
   end

   assign ready    = (state_q == ST_IDLE);
   assign busy     = (state_q != ST_IDLE);
   assign tick     = tick_q;
   assign done     = done_q;
   assign cnt      = cnt_val;
   assign rep_left = rep_left_q;

endmodule : timer_seq
`default_nettype wire

// File: tb/tb_timer_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_seq
// Description : Self-checking bench for timer_seq: a table of per-cycle
//               vectors plus hand-written sequences for strobe gating,
//               asynchronous reset and (when built in) pause.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       pause;
   logic       tick_en;
   logic [7:0] period;
   logic [3:0] repeat_cnt;
   logic       ready;
   logic       busy;
   logic       tick;
   logic       done;
   logic [7:0] cnt;
   logic [3:0] rep_left;

   int checks   = 0;
   int failures = 0;

   timer_seq #(
      .WIDTH (8),
      .REP_W (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
`ifdef TIMER_SEQ_PAUSE_EN
      .pause      (pause),
`endif
      .tick_en    (tick_en),
      .period     (period),
      .repeat_cnt (repeat_cnt),
      .ready      (ready),
      .busy       (busy),
      .tick       (tick),
      .done       (done),
      .cnt        (cnt),
      .rep_left   (rep_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       st;
      logic       sp;
      logic       te;
      logic [7:0] per;
      logic [3:0] rep;
      logic       rdy;
      logic       bsy;
      logic       tck;
      logic       dn;
      logic [7:0] c;
      logic [3:0] rl;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic st, input logic sp, input logic te,
                               input int per, input int rep,
                               input logic rdy, input logic bsy,
                               input logic tck, input logic dn,
                               input int c, input int rl);
      vec_t v;
      v.st  = st;  v.sp  = sp;  v.te = te;
      v.per = per[7:0]; v.rep = rep[3:0];
      v.rdy = rdy; v.bsy = bsy; v.tck = tck; v.dn = dn;
      v.c   = c[7:0]; v.rl = rl[3:0];
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string nm, input logic rdy, input logic bsy,
                          input logic tck, input logic dn, input int c, input int rl);
      chk({nm, ".ready"},    int'(ready),    int'(rdy));
      chk({nm, ".busy"},     int'(busy),     int'(bsy));
      chk({nm, ".tick"},     int'(tick),     int'(tck));
      chk({nm, ".done"},     int'(done),     int'(dn));
      chk({nm, ".cnt"},      int'(cnt),      c);
      chk({nm, ".rep_left"}, int'(rep_left), rl);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_c [6];
      int exp_t [6];

      //            st sp te per rep  rdy bsy tck dn cnt rl
      // period=3, repeat=0: tick+done 4 cycles after acceptance
      vecs[0]  = mk(1, 0, 1, 3, 0,   0, 1, 0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 1, 3, 0,   0, 1, 0, 0, 1, 0);
      vecs[2]  = mk(0, 0, 1, 3, 0,   0, 1, 0, 0, 2, 0);
      vecs[3]  = mk(0, 0, 1, 3, 0,   0, 1, 0, 0, 3, 0);
      vecs[4]  = mk(0, 0, 1, 3, 0,   1, 0, 1, 1, 0, 0);
      vecs[5]  = mk(0, 0, 1, 3, 0,   1, 0, 0, 0, 0, 0);
      // period=2, repeat=2: ticks at +3, +6, +9; start mid-run ignored (v10)
      vecs[6]  = mk(1, 0, 1, 2, 2,   0, 1, 0, 0, 0, 2);
      vecs[7]  = mk(0, 0, 1, 2, 2,   0, 1, 0, 0, 1, 2);
      vecs[8]  = mk(0, 0, 1, 2, 2,   0, 1, 0, 0, 2, 2);
      vecs[9]  = mk(0, 0, 1, 2, 2,   0, 1, 1, 0, 0, 1);
      vecs[10] = mk(1, 0, 1, 7, 5,   0, 1, 0, 0, 1, 1);
      vecs[11] = mk(0, 0, 1, 2, 2,   0, 1, 0, 0, 2, 1);
      vecs[12] = mk(0, 0, 1, 2, 2,   0, 1, 1, 0, 0, 0);
      vecs[13] = mk(0, 0, 1, 2, 2,   0, 1, 0, 0, 1, 0);
      vecs[14] = mk(0, 0, 1, 2, 2,   0, 1, 0, 0, 2, 0);
      vecs[15] = mk(0, 0, 1, 2, 2,   1, 0, 1, 1, 0, 0);
      // stop coincident with final interval end suppresses tick/done
      vecs[16] = mk(1, 0, 1, 1, 0,   0, 1, 0, 0, 0, 0);
      vecs[17] = mk(0, 0, 1, 1, 0,   0, 1, 0, 0, 1, 0);
      vecs[18] = mk(0, 1, 1, 1, 0,   1, 0, 0, 0, 0, 0);
      // stop beats start in IDLE
      vecs[19] = mk(1, 1, 1, 1, 0,   1, 0, 0, 0, 0, 0);
      // stop mid-run clears rep_left; tick_en=0 holds cnt
      vecs[20] = mk(1, 0, 1, 5, 3,   0, 1, 0, 0, 0, 3);
      vecs[21] = mk(0, 0, 0, 5, 3,   0, 1, 0, 0, 0, 3);
      vecs[22] = mk(0, 0, 1, 5, 3,   0, 1, 0, 0, 1, 3);
      vecs[23] = mk(0, 1, 1, 5, 3,   1, 0, 0, 0, 0, 0);
      // period=0 ticks on every strobe
      vecs[24] = mk(1, 0, 0, 0, 1,   0, 1, 0, 0, 0, 1);
      vecs[25] = mk(0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 1);
      vecs[26] = mk(0, 0, 1, 0, 1,   0, 1, 1, 0, 0, 0);
      vecs[27] = mk(0, 0, 1, 0, 1,   1, 0, 1, 1, 0, 0);

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      tick_en = 1'b0; period = '0; repeat_cnt = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1, 0, 0, 0, 0, 0);

      // Release reset and present the first start with no edge in between.
      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) begin
         start      = vecs[i].st;
         stop       = vecs[i].sp;
         tick_en    = vecs[i].te;
         period     = vecs[i].per;
         repeat_cnt = vecs[i].rep;
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].bsy,
                 vecs[i].tck, vecs[i].dn, int'(vecs[i].c), int'(vecs[i].rl));
      end

      // period=1, strobe every 3rd cycle: tick right after the 2nd strobe.
      stop = 1'b0; start = 1'b1; tick_en = 1'b0; period = 8'd1; repeat_cnt = 4'd0;
      step();
      chk_all("sparse.accept", 0, 1, 0, 0, 0, 0);
      start = 1'b0;
      exp_c = '{0, 0, 1, 1, 1, 0};
      exp_t = '{0, 0, 0, 0, 0, 1};
      for (int c = 0; c < 6; c++) begin
         tick_en = (c % 3 == 2);
         step();
         chk($sformatf("sparse%0d.cnt", c),  int'(cnt),  exp_c[c]);
         chk($sformatf("sparse%0d.tick", c), int'(tick), exp_t[c]);
         chk($sformatf("sparse%0d.done", c), int'(done), exp_t[c]);
      end
      tick_en = 1'b0;
      step();
      chk_all("sparse.after", 1, 0, 0, 0, 0, 0);

      // Asynchronous reset mid-run at cnt=5, then period=0 restart.
      start = 1'b1; tick_en = 1'b1; period = 8'd9; repeat_cnt = 4'd2;
      step();
      start = 1'b0;
      repeat (5) step();
      chk_all("midrun", 0, 1, 0, 0, 5, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 1, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      start = 1'b1; period = 8'd0; repeat_cnt = 4'd0; tick_en = 1'b1;
      step();
      chk_all("post_rst.accept", 0, 1, 0, 0, 0, 0);
      start = 1'b0;
      step();
      chk_all("post_rst.tick", 1, 0, 1, 1, 0, 0);

`ifdef TIMER_SEQ_PAUSE_EN
      // period=4, pause held 10 cycles at cnt=2, tick 3 strobes after release.
      start = 1'b1; period = 8'd4; repeat_cnt = 4'd0; tick_en = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      chk("pause.pre.cnt", int'(cnt), 2);
      pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk($sformatf("pause%0d.cnt", k),  int'(cnt),  2);
         chk($sformatf("pause%0d.busy", k), int'(busy), 1);
         chk($sformatf("pause%0d.tick", k), int'(tick), 0);
      end
      pause = 1'b0;
      step();
      chk("pause.release.cnt", int'(cnt), 2);
      step();
      chk("pause.s1.cnt", int'(cnt), 3);
      step();
      chk("pause.s2.cnt", int'(cnt), 4);
      step();
      chk_all("pause.s3", 1, 0, 1, 1, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_timer_seq
`default_nettype wire

// File: doc/timer_seq.md
TIMER_SEQ -- requirements
Module: timer_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and period width.
REQ-002 SHALL have parameter REP_W, default 4: repeat-count width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin a timing sequence.
REQ-006 SHALL have port stop  input  1  abort the current sequence.
REQ-007 SHALL have port tick_en  input  1  prescaler strobe; the counter advances only on strobe cycles.
REQ-008 SHALL have port period  input  WIDTH  the interval is period+1 strobes; sampled when start is accepted.
REQ-009 SHALL have port repeat  input  REP_W  the sequence runs repeat+1 intervals; sampled when start is accepted.
REQ-010 SHALL have port ready  output  1  high in IDLE only; start is accepted only when ready=1.
REQ-011 SHALL have port busy  output  1  high in RUN (and PAUSE when compiled in).
REQ-012 SHALL have port tick  output  1  one-cycle pulse at the end of each interval.
REQ-013 SHALL have port done  output  1  one-cycle pulse at the end of the final interval.
REQ-014 SHALL have port cnt  output  WIDTH  current counter value.
REQ-015 SHALL have port rep_left  output  REP_W  intervals remaining after the current one.

Function
REQ-016 SHALL implement an FSM with states IDLE and RUN, plus PAUSE when compiled in.
REQ-017 IDLE with start=1 and stop=0: SHALL latch period into period_q and repeat into rep_left, clear cnt, and enter RUN on the same edge.
REQ-018 start while not IDLE SHALL be ignored, with no effect on any state.
REQ-019 RUN with tick_en=1 and cnt!=period_q: SHALL set cnt to cnt+1 and leave tick at 0.
REQ-020 RUN with tick_en=1 and cnt==period_q: SHALL clear cnt and assert tick for exactly the next cycle.
REQ-021 Interval end (REQ-020) with rep_left!=0: SHALL decrement rep_left and stay in RUN.
REQ-022 Interval end (REQ-020) with rep_left==0: SHALL also assert done in the same cycle as tick and return to IDLE.
REQ-023 tick_en=0 SHALL hold cnt in every state.
REQ-024 period=0 SHALL produce a tick on every strobe.
REQ-025 Comparison and increment SHALL be unsigned WIDTH-bit; cnt never exceeds period_q, so no wrap occurs.
REQ-026 stop=1 in any non-IDLE state SHALL force IDLE on the next edge, clear cnt and rep_left, and suppress tick and done.
REQ-027 stop SHALL win over a coincident interval end, a coincident start, and a coincident pause.
REQ-028 tick and done SHALL be registered outputs.
REQ-029 ready and busy SHALL be decoded from registered state.
REQ-030 Minimum start-to-first-tick latency SHALL be period+1 strobes, with tick visible one cycle after the final strobe.

Reset
REQ-031 rst_n=0 SHALL force IDLE, cnt=0, rep_left=0, period_q=0, tick=0, done=0, busy=0, ready=1, asynchronously at any time, including mid-sequence.
REQ-032 The first start after reset deassertion SHALL be honoured on the first rising clk edge.

Configuration
REQ-033 Macro TIMER_SEQ_PAUSE_EN defined: SHALL add input pause (1 bit) and state PAUSE; RUN with pause=1 enters PAUSE, PAUSE with pause=0 returns to RUN; cnt and rep_left hold in PAUSE and tick_en is ignored there; busy stays 1 in PAUSE.
REQ-034 Macro TIMER_SEQ_PAUSE_EN undefined: SHALL have no pause port and no PAUSE state; behaviour otherwise identical.

Structure
REQ-035 A shared package timer_seq_pkg SHALL hold the FSM state typedef (IDLE, RUN, PAUSE) and the default WIDTH and REP_W constants.
REQ-036 The counter, with clr, inc and an eq compare against period_q, SHALL be a sub-module tick_counter; timer_seq drives its clr and inc.

Verification
REQ-037 period=3, repeat=0, tick_en=1 constant, start pulse: SHALL give tick and done together 4 cycles after acceptance; ready=1 thereafter.
REQ-038 period=2, repeat=2, tick_en=1: SHALL give ticks 3, 6 and 9 cycles after acceptance; done only with the 3rd tick; rep_left sequence 2,1,0.
REQ-039 period=1, repeat=0, tick_en high every 3rd cycle: SHALL give tick one cycle after the 2nd strobe; cnt holds between strobes.
REQ-040 stop asserted in the same cycle as the final interval end: SHALL give no tick, no done, IDLE next cycle, cnt=0.
REQ-041 rst_n pulsed low mid-RUN with cnt=5: SHALL give cnt=0, busy=0, ready=1 immediately; a subsequent start with period=0 SHALL tick on the 1st strobe.
REQ-042 With TIMER_SEQ_PAUSE_EN defined, period=4, pause held 10 cycles at cnt=2: SHALL hold cnt=2 throughout the pause; tick arrives 3 strobes after pause release.
